sprite_compositor: RTL
======================

Name: sprite_compositor

Overview:
- Pipelined per-pixel compositor for the VGA path. Merges NUM_SPRITES hardware sprites (circle or square) over a ROM-backed background image.
- Sits between the VGA controller (DrawX/DrawY/blank) and the DAC outputs. Also reports per-frame sprite collisions to game logic.

Parameters:
- NUM_SPRITES, 4, number of sprite layers; index 0 has highest priority
- COORD_W, 10, width of the DrawX/DrawY, sprite X/Y and size fields
- COLOR_W, 8, width of each colour channel
- H_ACTIVE, 640, active pixels per line; used for the background address
- V_ACTIVE, 480, active lines per frame
- BG_ADDR_W, 19, background ROM address width

Ports:
- vga_clk  in  1  pixel clock
- Reset_n  in  1  asynchronous active-low reset
- DrawX  in  COORD_W  current pixel column
- DrawY  in  COORD_W  current pixel row
- blank  in  1  1 = active video
- SprX  in  NUM_SPRITES*COORD_W  sprite centre X, packed; sprite i at [i*COORD_W +: COORD_W]
- SprY  in  NUM_SPRITES*COORD_W  sprite centre Y, packed
- SprSize  in  NUM_SPRITES*COORD_W  sprite radius / half-side
- SprEnable  in  NUM_SPRITES  1 = sprite i drawn
- SprShape  in  NUM_SPRITES  0 = circle, 1 = square
- SprBlend  in  NUM_SPRITES  blend request; used only under SPRITE_BLEND_EN
- SprColor  in  NUM_SPRITES*3*COLOR_W  packed {R,G,B} per sprite
- bg_addr  out  BG_ADDR_W  background ROM address
- bg_red, bg_green, bg_blue  in  COLOR_W each  palette output; ROM+palette latency is exactly 1 cycle after bg_addr
- Red, Green, Blue  out  COLOR_W each  final pixel colour
- blank_out  out  1  blank delayed to align with Red/Green/Blue
- collision_flags  out  NUM_SPRITES  per-sprite collision result of the last completed frame
- collision_valid  out  1  one-cycle pulse when collision_flags updates

Behaviour:
- Reset (async assert, sync release): all outputs and pipeline registers are 0.
- Fixed latency of 3 cycles from DrawX/DrawY/blank to Red/Green/Blue/blank_out. Pipeline is never stalled.
- Stage 1 (T+1):
  - Register bg_addr = DrawY*H_ACTIVE + DrawX when blank=1 and DrawX<H_ACTIVE and DrawY<V_ACTIVE; otherwise bg_addr=0.
  - Compute dx = DrawX - SprX[i] and dy = DrawY - SprY[i], signed, COORD_W+1 bits, no wrap.
  - Circle hit: dx*dx + dy*dy <= size*size, evaluated at 2*(COORD_W+1) bits.
  - Square hit: |dx| <= size and |dy| <= size.
  - hit[i] = hit result AND SprEnable[i]. Register hit vector and blank.
- Stage 2 (T+2): bg_* data is valid. Register bg colour and hit vector, and pick the lowest set index in hit.
- Stage 3 (T+3):
  - delayed blank=0 -> RGB = 0.
  - else any hit -> winning sprite's SprColor.
  - else -> background colour.
- Size 0 is a 1-pixel sprite at the centre. A sprite partly off-screen is clipped naturally with no wrap-around.
- Frame start = sample with DrawX==0 and DrawY==0, carried down the pipeline with the pixel.
- Collision accumulator:
  - On an active pixel at stage 2 where popcount(hit) >= 2, OR the hit vector into the accumulator.
  - When frame start reaches stage 2, copy the accumulator to collision_flags, pulse collision_valid for 1 cycle, and reload the accumulator with this pixel's contribution only.
- Reset mid-frame clears the accumulator. The first frame start after reset reports flags=0 with a valid pulse.
- Sprite registers are sampled each cycle. Changing them mid-frame takes effect on the next pixel and is not glitch-protected.

Optional Feature:
- SPRITE_BLEND_EN
- Defined: if the winning sprite has SprBlend=1, each output channel = (sprite + under) >> 1, computed at COLOR_W+1 bits. "under" is the next-priority hit sprite, or the background if there is none.
- Undefined: SprBlend is ignored and the winning sprite is fully opaque. Latency is 3 in both builds.

Test Plan:
- Background only: SprEnable=0, pixel (5,2) with blank=1 -> bg_addr=1285 at T+1; supply bg=(0x12,0x34,0x56) at T+2 -> RGB=(0x12,0x34,0x56) at T+3.
- Circle sprite 0 at (100,100), size 10, colour (FF,55,00): pixel (107,107) -> FF5500; pixel (108,108) -> background (128 > 100).
- Priority: sprite 0 (red) and sprite 1 (blue) both cover (50,50) -> red. Disable sprite 0 -> blue. blank=0 -> RGB=0 and blank_out=0 three cycles later.
- Collision:
  - Squares 1 and 2 overlap in frame N and sprite 3 is isolated -> at the next (0,0) plus 2 cycles, collision_valid pulses with flags=4'b0110.
  - A frame with no overlap -> flags=0.
- Reset_n low mid-line -> all outputs 0 immediately (asynchronous). After release, the first frame start reports flags=0.
- SPRITE_BLEND_EN build: blended sprite colour 0x80 over background 0x40 -> 0x60. Non-blend build gives 0x80.

Source files
------------

// File: rtl/sprite_compositor_if.sv
// Pixel/sprite/palette bundle between the VGA timing side and the compositor.
// master: VGA controller, sprite register bank and background ROM/palette.
// slave : sprite_compositor.
interface sprite_compositor_if #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 10,
  parameter int COLOR_W     = 8,
  parameter int BG_ADDR_W   = 19
);
  logic [COORD_W-1:0]               DrawX;
  logic [COORD_W-1:0]               DrawY;
  logic                             blank;
  logic [NUM_SPRITES*COORD_W-1:0]   SprX;
  logic [NUM_SPRITES*COORD_W-1:0]   SprY;
  logic [NUM_SPRITES*COORD_W-1:0]   SprSize;
  logic [NUM_SPRITES-1:0]           SprEnable;
  logic [NUM_SPRITES-1:0]           SprShape;
  logic [NUM_SPRITES-1:0]           SprBlend;
  logic [NUM_SPRITES*3*COLOR_W-1:0] SprColor;
  logic [BG_ADDR_W-1:0]             bg_addr;
  logic [COLOR_W-1:0]               bg_red;
  logic [COLOR_W-1:0]               bg_green;
  logic [COLOR_W-1:0]               bg_blue;
  logic [COLOR_W-1:0]               Red;
  logic [COLOR_W-1:0]               Green;
  logic [COLOR_W-1:0]               Blue;
  logic                             blank_out;
  logic [NUM_SPRITES-1:0]           collision_flags;
  logic                             collision_valid;

  modport master (
    output DrawX, DrawY, blank, SprX, SprY, SprSize, SprEnable, SprShape,
           SprBlend, SprColor, bg_red, bg_green, bg_blue,
    input  bg_addr, Red, Green, Blue, blank_out, collision_flags, collision_valid
  );

  modport slave (
    input  DrawX, DrawY, blank, SprX, SprY, SprSize, SprEnable, SprShape,
           SprBlend, SprColor, bg_red, bg_green, bg_blue,
    output bg_addr, Red, Green, Blue, blank_out, collision_flags, collision_valid
  );
endinterface

// File: rtl/sprite_compositor.sv
// Three-stage per-pixel compositor: NUM_SPRITES circle/square sprites over a
// ROM background, with per-frame sprite collision reporting.
// Optional build macro SPRITE_BLEND_EN: winning sprite with SprBlend set is
// averaged with the layer beneath it (next hit sprite, else background).
module sprite_compositor #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 10,
  parameter int COLOR_W     = 8,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BG_ADDR_W   = 19
) (
  input  logic              vga_clk,
  input  logic              Reset_n,
  sprite_compositor_if.slave bus
);
  localparam int SQ_W  = 2 * (COORD_W + 1);
  localparam int RGB_W = 3 * COLOR_W;
  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [COORD_W:0]     H_LIM = (COORD_W + 1)'(H_ACTIVE);
  localparam logic [COORD_W:0]     V_LIM = (COORD_W + 1)'(V_ACTIVE);
  localparam logic [BG_ADDR_W-1:0] H_MUL = BG_ADDR_W'(H_ACTIVE);

  logic [1:0] rst_sync_q;
  logic       pipe_rst_n;

  // Reset asserts asynchronously, releases on a clock edge
  always_ff @(posedge vga_clk or negedge Reset_n) begin
    if (!Reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign pipe_rst_n = rst_sync_q[1];

  // ---------------- stage 1: address and hit test ----------------
  logic [NUM_SPRITES-1:0] hit_d;
  logic [BG_ADDR_W-1:0]   bg_addr_d;
  logic                   in_active;
  logic                   fs_d;
  logic [RGB_W-1:0]       spr_col [NUM_SPRITES];

  assign in_active = bus.blank && ({1'b0, bus.DrawX} < H_LIM) && ({1'b0, bus.DrawY} < V_LIM);
  assign bg_addr_d = in_active ? (BG_ADDR_W'(bus.DrawY) * H_MUL + BG_ADDR_W'(bus.DrawX)) : '0;
  assign fs_d      = (bus.DrawX == '0) && (bus.DrawY == '0);

  // Distances are widened by one bit so off-screen parts never wrap back in
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    logic signed [COORD_W:0] dx, dy;
    logic [COORD_W:0]        adx, ady;
    logic [COORD_W-1:0]      size;
    logic [SQ_W-1:0]         dist2, rad2;
    logic                    in_circ, in_sq;

    assign size    = bus.SprSize[g*COORD_W +: COORD_W];
    assign dx      = $signed({1'b0, bus.DrawX}) - $signed({1'b0, bus.SprX[g*COORD_W +: COORD_W]});
    assign dy      = $signed({1'b0, bus.DrawY}) - $signed({1'b0, bus.SprY[g*COORD_W +: COORD_W]});
    assign adx     = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
    assign ady     = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
    assign dist2   = SQ_W'(adx) * SQ_W'(adx) + SQ_W'(ady) * SQ_W'(ady);
    assign rad2    = SQ_W'(size) * SQ_W'(size);
    assign in_circ = (dist2 <= rad2);
    assign in_sq   = (adx <= {1'b0, size}) && (ady <= {1'b0, size});
    assign hit_d[g] = bus.SprEnable[g] & (bus.SprShape[g] ? in_sq : in_circ);
    assign spr_col[g] = bus.SprColor[g*RGB_W +: RGB_W];
  end

  logic [BG_ADDR_W-1:0]   bg_addr_q;
  logic [NUM_SPRITES-1:0] hit1_q;
  logic                   blank1_q;
  logic                   fs1_q;

  // Stage 1 registers
  always_ff @(posedge vga_clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      bg_addr_q <= '0;
      hit1_q    <= '0;
      blank1_q  <= 1'b0;
      fs1_q     <= 1'b0;
    end else begin
      bg_addr_q <= bg_addr_d;
      hit1_q    <= hit_d;
      blank1_q  <= bus.blank;
      fs1_q     <= fs_d;
    end
  end
  assign bus.bg_addr = bg_addr_q;

  // ---------------- stage 2: priority select, collisions ----------------
  logic             win_any, sec_any;
  logic [IDX_W-1:0] win_idx, sec_idx;
  logic [RGB_W-1:0] bg_rgb;
  logic [RGB_W-1:0] spr2_d, under2_d;
  logic             blend2_d;
  logic             multi;
  logic [NUM_SPRITES-1:0] acc_d, acc_q, flags_d, flags_q;
  logic             valid_d, valid_q;

  assign bg_rgb = {bus.bg_red, bus.bg_green, bus.bg_blue};

  // Lowest set index wins; the next set index is the layer beneath it
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    sec_any = 1'b0;
    sec_idx = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (hit1_q[i]) begin
        if (!win_any) begin
          win_any = 1'b1;
          win_idx = IDX_W'(i);
        end else if (!sec_any) begin
          sec_any = 1'b1;
          sec_idx = IDX_W'(i);
        end
      end
    end
  end

  // Colour operands for the final mux
  always_comb begin
    spr2_d   = spr_col[win_idx];
    under2_d = bg_rgb;
    blend2_d = 1'b0;
`ifdef SPRITE_BLEND_EN
    blend2_d = win_any & bus.SprBlend[win_idx];
    if (sec_any) under2_d = spr_col[sec_idx];
`endif
  end

`ifndef SPRITE_BLEND_EN
  logic unused_blend;
  assign unused_blend = ^{bus.SprBlend, sec_idx};
`endif

  // Two or more hits on one active pixel is a collision for all of them
  always_comb begin
    multi   = blank1_q & sec_any;
    acc_d   = acc_q;
    flags_d = flags_q;
    valid_d = 1'b0;
    if (fs1_q) begin
      flags_d = acc_q;
      valid_d = 1'b1;
      acc_d   = multi ? hit1_q : '0;
    end else if (multi) begin
      acc_d = acc_q | hit1_q;
    end
  end

  logic             any2_q, blank2_q, blend2_q;
  logic [RGB_W-1:0] spr2_q, under2_q;

  // Stage 2 registers
  always_ff @(posedge vga_clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      any2_q   <= 1'b0;
      blank2_q <= 1'b0;
      blend2_q <= 1'b0;
      spr2_q   <= '0;
      under2_q <= '0;
      acc_q    <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      any2_q   <= win_any;
      blank2_q <= blank1_q;
      blend2_q <= blend2_d;
      spr2_q   <= spr2_d;
      under2_q <= under2_d;
      acc_q    <= acc_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end
  assign bus.collision_flags = flags_q;
  assign bus.collision_valid = valid_q;

  // ---------------- stage 3: output mux ----------------
  logic [RGB_W-1:0] avg_rgb, rgb3_d, rgb3_q;
  logic             blank3_q;

  for (genvar c = 0; c < 3; c++) begin : g_avg
    logic [COLOR_W:0] sum;
    assign sum = {1'b0, spr2_q[c*COLOR_W +: COLOR_W]} + {1'b0, under2_q[c*COLOR_W +: COLOR_W]};
    assign avg_rgb[c*COLOR_W +: COLOR_W] = COLOR_W'(sum >> 1);
  end

  // Blanked pixels are forced black; otherwise sprite over background
  always_comb begin
    rgb3_d = '0;
    if (blank2_q) begin
      if (any2_q) rgb3_d = blend2_q ? avg_rgb : spr2_q;
      else        rgb3_d = under2_q;
    end
  end

  // Stage 3 registers
  always_ff @(posedge vga_clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      rgb3_q   <= '0;
      blank3_q <= 1'b0;
    end else begin
      rgb3_q   <= rgb3_d;
      blank3_q <= blank2_q;
    end
  end
  assign bus.Red       = rgb3_q[3*COLOR_W-1:2*COLOR_W];
  assign bus.Green     = rgb3_q[2*COLOR_W-1:COLOR_W];
  assign bus.Blue      = rgb3_q[COLOR_W-1:0];
  assign bus.blank_out = blank3_q;
endmodule
